imm_extend_arbiter: RTL and testbench
=====================================

IMM_EXTEND_ARBITER -- requirements
Module: imm_extend_arbiter

Interface
REQ-001 The block SHALL have parameter IN_W, default 22, immediate field width.
REQ-002 The block SHALL have parameter OUT_W, default 32, extended result width; OUT_W > IN_W.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port req0  input  1  requester 0 wants an extension; held high until ack0.
REQ-007 Port imm0  input  IN_W  requester 0 immediate; stable while req0 high.
REQ-008 Port zext0  input  1  requester 0 mode: 1 = zero-extend, 0 = sign-extend.
REQ-009 Port ack0  output  1  one-cycle pulse: requester 0 operand captured.
REQ-010 Ports req1, imm1, zext1, ack1 SHALL mirror REQ-006..REQ-009 for requester 1.
REQ-011 Port res_valid  output  1  res_data/res_src hold a valid result.
REQ-012 Port res_data  output  OUT_W  extended immediate.
REQ-013 Port res_src  output  1  index of the requester that owns res_data.
REQ-014 Port res_ready  input  1  consumer accepts the result when high with res_valid.
REQ-015 Port busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CALC, RESP; all outputs registered.
REQ-017 IDLE: no request -> stay IDLE.
REQ-018 IDLE: req0 or req1 high at an edge -> capture the winner's imm, zext and index at that edge; go to CALC.
REQ-019 Arbitration: a single requester is granted directly; both high -> grant the requester named by the priority pointer.
REQ-020 Priority pointer SHALL reset to 0 and, on each completed handshake, be set to the requester not just served (round-robin).
REQ-021 CALC: lasts exactly one cycle; ack of the granted requester high for this cycle only; other ack low; result computed into the result register; go to RESP.
REQ-022 Sign-extend: res_data[IN_W-1:0] = imm; bits OUT_W-1..IN_W = imm[IN_W-1].
REQ-023 Zero-extend: res_data[IN_W-1:0] = imm; bits OUT_W-1..IN_W = 0.
REQ-024 RESP: res_valid = 1; res_data and res_src stable until res_valid and res_ready both high at an edge, then go to IDLE with res_valid = 0 the next cycle.
REQ-025 Latency: request sampled at edge N -> ack high in cycle N+1 -> res_valid high from cycle N+2; minimum 3 cycles per transaction; no back-to-back capture from RESP.
REQ-026 Requests arriving in CALC or RESP SHALL be ignored until the FSM returns to IDLE; the requester keeps req high.
REQ-027 res_ready high outside RESP SHALL have no effect.
REQ-028 busy = 1 in CALC and RESP, 0 in IDLE.

Reset
REQ-029 Reset at an edge SHALL force IDLE, ack0 = ack1 = 0, res_valid = 0, res_data = 0, res_src = 0, busy = 0 and priority pointer = 0, taking priority over all other inputs.
REQ-030 Reset in CALC or RESP SHALL abandon the transaction with no further ack or result; the requester must re-request.
REQ-031 After reset deasserts, the first request may be sampled at the next edge.

Verification
REQ-032 req0=1, imm0=22, zext0=0 -> ack0 pulse one cycle later; res_data=0x00000016, res_src=0 one cycle after that.
REQ-033 req1=1, imm1=0x3FFFEA (-22), zext1=0 -> res_data=0xFFFFFFEA, res_src=1; repeat with zext1=1 -> res_data=0x003FFFEA.
REQ-034 After reset, req0 and req1 both held high with imm0=63, imm1=-45, res_ready=1 -> first result 0x0000003F (src 0), then 0xFFFFFFD3 (src 1); third grant goes to 0.
REQ-035 In RESP hold res_ready=0 for 5 cycles with req0 toggling -> res_valid stays 1; res_data and res_src unchanged; no ack asserted; completion on the first res_ready=1 edge.
REQ-036 Assert reset in CALC, and separately in RESP -> next cycle res_valid=0, ack0=ack1=0, busy=0; a fresh req1 after reset is served normally.

Source files
------------

// File: rtl/imm_extend_arbiter.sv
// ============================================================================
// Module   : imm_extend_arbiter
// Brief    : Two-requester round-robin arbiter feeding a sign/zero immediate
//            extender with a registered valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extend_arbiter #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [IN_W-1:0]  imm0,
  input  logic             zext0,
  output logic             ack0,
  input  logic             req1,
  input  logic [IN_W-1:0]  imm1,
  input  logic             zext1,
  output logic             ack1,
  output logic             res_valid,
  output logic [OUT_W-1:0] res_data,
  output logic             res_src,
  input  logic             res_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic [IN_W-1:0]  cap_imm;
  logic             cap_zext;
  logic             cap_src;
  logic             grant;
  logic             ext_bit;
  logic [OUT_W-1:0] ext_data;

  // A lone requester wins outright; contention is settled by the pointer.
  assign grant    = (req0 && req1) ? ptr : req1;
  assign ext_bit  = ~cap_zext & cap_imm[IN_W-1];
  assign ext_data = {{(OUT_W-IN_W){ext_bit}}, cap_imm};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      cap_imm   <= '0;
      cap_zext  <= 1'b0;
      cap_src   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_src   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cap_imm  <= grant ? imm1 : imm0;
            cap_zext <= grant ? zext1 : zext0;
            cap_src  <= grant;
            ack0     <= ~grant;
            ack1     <= grant;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          res_data  <= ext_data;
          res_src   <= cap_src;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Round-robin hand-off happens only once the consumer takes the result.
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= ~res_src;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_arbiter.sv
// ============================================================================
// Module   : tb_imm_extend_arbiter
// Brief    : Scoreboard bench for imm_extend_arbiter (ack and result queues).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_extend_arbiter;
  localparam int IN_W  = 22;
  localparam int OUT_W = 32;

  logic             clk;
  logic             reset;
  logic             req0, req1, zext0, zext1;
  logic [IN_W-1:0]  imm0, imm1;
  logic             ack0, ack1;
  logic             res_valid, res_src, res_ready, busy;
  logic [OUT_W-1:0] res_data;

  int checks = 0;
  int errors = 0;

  logic [OUT_W-1:0] exp_data_q[$];
  logic             exp_src_q[$];
  logic             exp_ack_q[$];

  imm_extend_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .imm0(imm0), .zext0(zext0), .ack0(ack0),
    .req1(req1), .imm1(imm1), .zext1(zext1), .ack1(ack1),
    .res_valid(res_valid), .res_data(res_data), .res_src(res_src),
    .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack and every accepted result is matched against the queues.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      chk("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
      if (exp_ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: got ack0=%b ack1=%b expected none", ack0, ack1);
      end else begin
        chk("ack_src", {31'b0, ack1}, {31'b0, exp_ack_q.pop_front()});
      end
    end
    if (res_valid && res_ready) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got data=%0h src=%b expected none", res_data, res_src);
      end else begin
        chk("res_data", res_data, exp_data_q.pop_front());
        chk("res_src", {31'b0, res_src}, {31'b0, exp_src_q.pop_front()});
      end
    end
  end

  // Raise one request from IDLE, expect ack two negedges later, then drop req.
  task automatic issue(input bit idx, input logic [IN_W-1:0] imm, input bit zext,
                       input logic [31:0] exp, input bit push_res);
    int n;
    @(posedge clk); #1;
    exp_ack_q.push_back(idx);
    if (push_res) begin
      exp_data_q.push_back(exp);
      exp_src_q.push_back(idx);
    end
    if (idx) begin req1 = 1'b1; imm1 = imm; zext1 = zext; end
    else     begin req0 = 1'b1; imm0 = imm; zext0 = zext; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idx ? ack1 : ack0) && n < 20);
    chk("ack_latency", n, 32'd2);
    chk("busy_in_calc", {31'b0, busy}, 32'd1);
    if (idx) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 50);
    chk("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_res_valid"}, {31'b0, res_valid}, 32'd0);
    chk({tag, "_ack0"}, {31'b0, ack0}, 32'd0);
    chk({tag, "_ack1"}, {31'b0, ack1}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacks;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; zext0 = 1'b0; zext1 = 1'b0;
    imm0 = '0; imm1 = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_res_data", res_data, 32'd0);
    chk("reset_res_src", {31'b0, res_src}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic sign extension of a positive value, with latency checks.
    issue(1'b0, 22'd22, 1'b0, 32'h0000_0016, 1'b1);
    @(negedge clk);
    chk("res_valid_latency", {31'b0, res_valid}, 32'd1);
    wait_idle();

    // Negative value on requester 1, sign- then zero-extended.
    issue(1'b1, 22'h3FFFEA, 1'b0, 32'hFFFF_FFEA, 1'b1);
    wait_idle();
    issue(1'b1, 22'h3FFFEA, 1'b1, 32'h003F_FFEA, 1'b1);
    wait_idle();

    // Contention after reset: grants must go 0, 1, 0.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_ack_q.push_back(1'b0); exp_ack_q.push_back(1'b1); exp_ack_q.push_back(1'b0);
    exp_data_q.push_back(32'h0000_003F); exp_src_q.push_back(1'b0);
    exp_data_q.push_back(32'hFFFF_FFD3); exp_src_q.push_back(1'b1);
    exp_data_q.push_back(32'h0000_003F); exp_src_q.push_back(1'b0);
    req0 = 1'b1; imm0 = 22'd63; zext0 = 1'b0;
    req1 = 1'b1; imm1 = 22'h3FFFD3; zext1 = 1'b0;
    nacks = 0;
    for (int i = 0; i < 60 && nacks < 3; i++) begin
      @(negedge clk);
      if (ack0 || ack1) nacks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contention_grants", nacks, 32'd3);
    wait_idle();

    // Back-pressure in RESP while req0 toggles.
    res_ready = 1'b0;
    issue(1'b0, 22'h2AAAAA, 1'b0, 32'hFFEA_AAAA, 1'b1);
    @(negedge clk);
    chk("stall_enter_valid", {31'b0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 req0 = ~req0;
      @(negedge clk);
      chk("stall_valid", {31'b0, res_valid}, 32'd1);
      chk("stall_data", res_data, 32'hFFEA_AAAA);
      chk("stall_src", {31'b0, res_src}, 32'd0);
    end
    @(posedge clk); #1 req0 = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_valid", {31'b0, res_valid}, 32'd0);
    chk("stall_release_busy", {31'b0, busy}, 32'd0);

    // Reset while in CALC abandons the transaction.
    issue(1'b1, 22'h000155, 1'b0, 32'h0000_0155, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_quiet("rst_calc");
    issue(1'b1, 22'h3FFFEA, 1'b1, 32'h003F_FFEA, 1'b1);
    wait_idle();

    // Reset while in RESP abandons the held result.
    res_ready = 1'b0;
    issue(1'b1, 22'h000155, 1'b0, 32'h0000_0155, 1'b0);
    @(negedge clk);
    chk("rst_resp_pre_valid", {31'b0, res_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    chk_quiet("rst_resp");
    chk("rst_resp_data", res_data, 32'd0);
    issue(1'b1, 22'h000077, 1'b1, 32'h0000_0077, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("ack_queue_drained", exp_ack_q.size(), 32'd0);
    chk("res_queue_drained", exp_data_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
